// File: rtl/pc_stack_unit.sv
// Program counter plus descending hardware stack controller: PC commands, call/return,
// data push/pop, bounds checking with a sticky fault, and a two-cycle return sequence.
module pc_stack_unit #(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   PC_RESET = '0,
    parameter logic [AW-1:0]   SP_TOP   = 16'h018F,
    parameter int              DEPTH    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_inc,
    input  logic          pc_jmp,
    input  logic          pc_rel,
    input  logic          call,
    input  logic          ret,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] mem_rdata,
    input  logic          fault_clr,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] sp_out,
    output logic [AW-1:0] stack_addr,
    output logic          stack_wr,
    output logic [AW-1:0] stack_wdata,
    output logic          stack_rd,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic          fault,
    output logic [1:0]    fault_code
);

    typedef enum logic {S_IDLE, S_RET_WAIT} state_t;

    localparam logic [AW-1:0] DEPTH_V = AW'(DEPTH);
    localparam logic [1:0]    FC_OVF  = 2'b01;
    localparam logic [1:0]    FC_UNF  = 2'b10;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_sp;
    logic [AW-1:0] r_count;
    logic          r_fault;
    logic [1:0]    r_fault_code;

    logic          w_idle, w_empty, w_full;
    logic          w_ret, w_call, w_pp;
    logic          w_call_ok, w_call_ovf, w_ret_ok, w_ret_unf;
    logic          w_push_ok, w_push_ovf, w_pop_ok, w_pop_unf;
    logic          w_ovf, w_unf;
    logic [AW-1:0] w_pc_plus1;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_count_nxt;

    assign w_idle  = (r_state == S_IDLE);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_V);

    // Command decode: ret beats call, and push/pop only count when neither is present.
    assign w_ret      = w_idle & ret;
    assign w_call     = w_idle & ~ret & call;
    assign w_pp       = w_idle & ~ret & ~call;
    assign w_call_ok  = w_call & ~w_full;
    assign w_call_ovf = w_call &  w_full;
    assign w_ret_ok   = w_ret  & ~w_empty;
    assign w_ret_unf  = w_ret  &  w_empty;
    assign w_push_ok  = w_pp & push & ~pop & ~w_full;
    assign w_push_ovf = w_pp & push & ~pop &  w_full;
    assign w_pop_ok   = w_pp & pop & ~push & ~w_empty;
    assign w_pop_unf  = w_pp & pop & ~push &  w_empty;
    assign w_ovf      = w_call_ovf | w_push_ovf;
    assign w_unf      = w_ret_unf  | w_pop_unf;

    assign w_pc_plus1 = r_pc + 1'b1;

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_ret) begin
            w_pc_nxt = r_pc;
        end else if (w_call) begin
            if (w_call_ok) w_pc_nxt = target;
        end else if (pc_jmp) begin
            w_pc_nxt = target;
        end else if (pc_rel) begin
            w_pc_nxt = r_pc + target;
        end else if (pc_inc) begin
            w_pc_nxt = w_pc_plus1;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_call_ok | w_push_ok)     w_count_nxt = r_count + 1'b1;
        else if (w_ret_ok | w_pop_ok)  w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= PC_RESET;
            r_sp         <= SP_TOP;
            r_count      <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pc <= w_pc_nxt;
                    if (w_ret_ok) r_state <= S_RET_WAIT;
                end
                S_RET_WAIT: begin
                    r_pc    <= mem_rdata;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            r_count <= w_count_nxt;
            r_sp    <= SP_TOP - w_count_nxt;
            // A new violation overrides a simultaneous clear; otherwise the first code is held.
            if (w_ovf | w_unf) begin
                r_fault <= 1'b1;
                if (!r_fault || fault_clr) r_fault_code <= w_ovf ? FC_OVF : FC_UNF;
            end else if (fault_clr) begin
                r_fault      <= 1'b0;
                r_fault_code <= 2'b00;
            end
        end
    end

    assign pc_out      = r_pc;
    assign sp_out      = r_sp;
    assign busy        = (r_state == S_RET_WAIT);
    assign empty       = w_empty;
    assign full        = w_full;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign stack_wr    = w_call_ok | w_push_ok;
    assign stack_rd    = w_ret_ok  | w_pop_ok;
    assign stack_wdata = w_call_ok ? w_pc_plus1 : '0;
    assign stack_addr  = (w_ret_ok | w_pop_ok) ? r_sp + 1'b1 : r_sp;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed-vector bench for pc_stack_unit with hand-computed expectations.
module tb_pc_stack_unit;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset, pc_inc, pc_jmp, pc_rel, call, ret, push, pop, fault_clr;
    logic [AW-1:0] target, mem_rdata;
    logic [AW-1:0] pc_out, sp_out, stack_addr, stack_wdata;
    logic          stack_wr, stack_rd, busy, empty, full, fault;
    logic [1:0]    fault_code;

    int n_checks = 0;
    int n_err    = 0;

    pc_stack_unit #(.AW(AW), .PC_RESET(16'h0000), .SP_TOP(16'h018F), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .pc_inc(pc_inc), .pc_jmp(pc_jmp), .pc_rel(pc_rel),
        .call(call), .ret(ret), .push(push), .pop(pop), .target(target),
        .mem_rdata(mem_rdata), .fault_clr(fault_clr), .pc_out(pc_out), .sp_out(sp_out),
        .stack_addr(stack_addr), .stack_wr(stack_wr), .stack_wdata(stack_wdata),
        .stack_rd(stack_rd), .busy(busy), .empty(empty), .full(full), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_inc = 0; pc_jmp = 0; pc_rel = 0; call = 0; ret = 0;
        push = 0; pop = 0; fault_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1; target = '0; mem_rdata = '0;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_sp", sp_out, 16'h018F);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_wr", stack_wr, 0);
        chk("rst_rd", stack_rd, 0);
        chk("rst_wdata", stack_wdata, 16'h0000);
        chk("rst_addr", stack_addr, 16'h018F);

        for (int i = 1; i <= 3; i++) begin
            pc_inc = 1; tick();
            chk($sformatf("inc_pc%0d", i), pc_out, i);
        end
        idle_inputs();
        chk("inc_sp", sp_out, 16'h018F);

        pc_jmp = 1; pc_inc = 1; target = 16'h0010; tick();
        chk("jmp_pri_pc", pc_out, 16'h0010);
        idle_inputs();

        call = 1; pc_jmp = 1; target = 16'h0200; #1;
        chk("call_wr", stack_wr, 1);
        chk("call_addr", stack_addr, 16'h018F);
        chk("call_wdata", stack_wdata, 16'h0011);
        chk("call_rd", stack_rd, 0);
        tick();
        chk("call_pc", pc_out, 16'h0200);
        chk("call_sp", sp_out, 16'h018E);
        chk("call_empty", empty, 0);
        idle_inputs();

        ret = 1; #1;
        chk("ret_rd", stack_rd, 1);
        chk("ret_addr", stack_addr, 16'h018F);
        chk("ret_wr", stack_wr, 0);
        tick();
        chk("ret_busy", busy, 1);
        chk("ret_sp", sp_out, 16'h018F);
        chk("ret_pc_hold", pc_out, 16'h0200);
        ret = 0; pc_inc = 1; push = 1; mem_rdata = 16'h0011; #1;
        chk("busy_no_wr", stack_wr, 0);
        tick();
        chk("ret_pc", pc_out, 16'h0011);
        chk("ret_busy_end", busy, 0);
        chk("busy_sp_hold", sp_out, 16'h018F);
        idle_inputs();

        pc_inc = 1; push = 1; #1;
        chk("push_wr", stack_wr, 1);
        chk("push_addr", stack_addr, 16'h018F);
        chk("push_wdata", stack_wdata, 16'h0000);
        tick();
        chk("incpush_pc", pc_out, 16'h0012);
        pc_inc = 0;
        for (int i = 1; i < 64; i++) tick();
        chk("full_flag", full, 1);
        chk("full_sp", sp_out, 16'h014F);
        #1;
        chk("ovf_wr", stack_wr, 0);
        tick();
        chk("ovf_fault", fault, 1);
        chk("ovf_code", fault_code, 2'b01);
        chk("ovf_sp", sp_out, 16'h014F);
        push = 0; pop = 1; #1;
        chk("pop_rd", stack_rd, 1);
        chk("pop_addr", stack_addr, 16'h0150);
        tick();
        chk("pop_sp", sp_out, 16'h0150);
        chk("pop_full", full, 0);
        chk("pop_code_hold", fault_code, 2'b01);
        pop = 0; fault_clr = 1; tick();
        chk("clr_fault", fault, 0);
        chk("clr_code", fault_code, 2'b00);
        fault_clr = 0;

        pop = 1;
        for (int i = 0; i < 63; i++) tick();
        chk("drain_empty", empty, 1);
        chk("drain_sp", sp_out, 16'h018F);
        #1;
        chk("unf_rd", stack_rd, 0);
        tick();
        chk("unf_code", fault_code, 2'b10);
        chk("unf_sp", sp_out, 16'h018F);
        push = 1; #1;
        chk("pp_wr", stack_wr, 0);
        chk("pp_rd", stack_rd, 0);
        tick();
        chk("pp_sp", sp_out, 16'h018F);
        idle_inputs();
        fault_clr = 1; tick();
        chk("clr2_fault", fault, 0);
        pop = 1; tick();
        chk("clr_vs_viol_fault", fault, 1);
        chk("clr_vs_viol_code", fault_code, 2'b10);
        idle_inputs();
        fault_clr = 1; tick();
        fault_clr = 0; ret = 1; #1;
        chk("ret_empty_rd", stack_rd, 0);
        tick();
        chk("ret_empty_busy", busy, 0);
        chk("ret_empty_pc", pc_out, 16'h0012);
        chk("ret_empty_code", fault_code, 2'b10);
        idle_inputs();
        fault_clr = 1; tick();
        fault_clr = 0;

        pc_jmp = 1; target = 16'h0002; tick();
        pc_jmp = 0; pc_rel = 1; pc_inc = 1; target = 16'hFFFC; tick();
        chk("rel_pc", pc_out, 16'hFFFE);
        idle_inputs();
        pc_jmp = 1; target = 16'hFFFF; tick();
        pc_jmp = 0; pc_inc = 1; tick();
        chk("wrap_pc", pc_out, 16'h0000);
        chk("wrap_fault", fault, 0);
        idle_inputs();

        call = 1; target = 16'h0300; tick();
        call = 0; ret = 1; tick();
        chk("rstw_busy_pre", busy, 1);
        ret = 0; reset = 1; mem_rdata = 16'h1234; tick();
        reset = 0;
        chk("rstw_pc", pc_out, 16'h0000);
        chk("rstw_busy", busy, 0);
        chk("rstw_sp", sp_out, 16'h018F);
        chk("rstw_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter and hardware-stack controller replacing the separate PC, PC-counter and stack-pointer blocks in the GPP datapath. It holds the PC and a descending stack pointer, executes increment / absolute jump / relative branch / call / return commands from the control unit, and drives data-memory address and strobes for stack traffic. It adds bounds checking with a sticky fault and a two-cycle return sequence that waits on data-memory read data.

## Interface
- AW, 16, address width of PC, SP and all address ports
- PC_RESET, 0, PC value after reset
- SP_TOP, 16'h018F, SP value when stack is empty (reset value)
- DEPTH, 64, max entries; legal SP range SP_TOP-DEPTH .. SP_TOP; requires DEPTH <= SP_TOP
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  one clock; reset is synchronous and active-high
- pc_inc  input  1  PC <= PC+1
- pc_jmp  input  1  PC <= target
- pc_rel  input  1  PC <= PC + target (two's complement, mod 2^AW)
- call  input  1  push PC+1, PC <= target
- ret  input  1  pop return address into PC (two cycles)
- push  input  1  data push: SP <= SP-1
- pop  input  1  data pop: SP <= SP+1
- target  input  AW  jump address or signed offset
- mem_rdata  input  AW  data-memory read data, valid the cycle after stack_rd
- fault_clr  input  1  clears sticky fault
- pc_out  output  AW  current PC (registered)
- sp_out  output  AW  current SP = SP_TOP - count (registered)
- stack_addr  output  AW  data-memory address for stack access (combinational)
- stack_wr  output  1  write strobe; write data is stack_wdata
- stack_wdata  output  AW  PC+1 during call, else 0
- stack_rd  output  1  read strobe for ret
- busy  output  1  high in RET_WAIT; all commands ignored
- empty, full  output  1  count==0 / count==DEPTH
- fault  output  1  sticky; set on overflow or underflow
- fault_code  output  2  01 overflow, 10 underflow, 00 none; holds first fault

## Operation
- Internal count register, 0..DEPTH; sp_out derived from it.
- FSM: IDLE, RET_WAIT. Reset -> IDLE.
- IDLE command priority: ret > call > pc_jmp > pc_rel > pc_inc; push/pop evaluated only when no call/ret is asserted.
- call: if !full: stack_addr=sp_out, stack_wr=1, stack_wdata=pc_out+1, count+1, PC<=target. If full: no write, PC and count unchanged, overflow fault.
- ret: if !empty: stack_addr=sp_out+1, stack_rd=1, count-1, go RET_WAIT. If empty: no read, stay IDLE, PC unchanged, underflow fault.
- RET_WAIT: PC <= mem_rdata, back to IDLE; busy=1; inputs ignored.
- push: if !full: stack_addr=sp_out, stack_wr=1 (data from regfile path), count+1. Full: overflow fault, no write.
- pop: if !empty: stack_addr=sp_out+1, stack_rd=1, count-1. Empty: underflow fault.
- push and pop same cycle: count unchanged, no strobes, no fault.
- PC commands combine with push/pop in the same cycle (e.g. pc_inc+push).
- PC wraps mod 2^AW on increment, relative branch and PC+1; no fault.
- fault: set on first violation, fault_code latched then frozen until fault_clr or reset; fault_clr same cycle as new violation -> violation wins.
- Idle strobes low, stack_addr = sp_out.

## Timing
- Reset values: pc_out=PC_RESET, sp_out=SP_TOP, count=0, empty=1, full=0, fault=0, fault_code=00, busy=0, stack_wr=0, stack_rd=0, stack_wdata=0.
- Reset mid-RET_WAIT: return to IDLE, mem_rdata discarded, all values above.
- PC/SP commands: one-cycle latency; new pc_out/sp_out visible after the edge.
- ret: 2 cycles; new PC visible after second edge; sp_out updated after first edge.
- Strobes and stack_addr are combinational from command inputs and state; memory samples on the same edge.
- empty/full/fault track registered state; fault visible the cycle after the violating command.

## Test plan
- Reset then 3x pc_inc -> pc_out 0,1,2,3; sp_out=0x018F, empty=1.
- pc_out=0x0010, call target=0x0200 -> stack_wr=1, stack_addr=0x018F, stack_wdata=0x0011; next pc_out=0x0200, sp_out=0x018E.
- ret with mem_rdata=0x0011 in cycle 2 -> stack_rd=1, stack_addr=0x018F, busy=1 one cycle, pc_out=0x0011, sp_out=0x018F; pc_inc during busy ignored.
- DEPTH pushes -> full=1, sp_out=0x014F; extra push -> no stack_wr, fault=1, fault_code=01; pop -> count DEPTH-1, code still 01; fault_clr -> 00.
- pop on empty -> fault_code=10, sp_out=0x018F; push+pop together -> sp_out unchanged, no strobes.
- pc_out=0x0002, pc_rel target=0xFFFC -> pc_out=0xFFFE; pc_out=0xFFFF, pc_inc -> 0x0000; reset during RET_WAIT -> pc_out=0, busy=0.
